// File: rtl/lvds_rx_word_aligner.sv
// LVDS receiver word aligner.
// After the init sequencer reports DONE, searches for the deserializer word
// boundary by comparing received words against a training pattern and pulsing
// bitslip until the pattern is seen MATCH_COUNT times in a row. Once locked,
// received words are forwarded as payload. If every bit position has been
// tried without lock, align_error is raised and the search stops.
module lvds_rx_word_aligner #(
  parameter int                    DATA_WIDTH    = 10,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 10'b1111100000,
  parameter int                    MATCH_COUNT   = 16,
  parameter int                    SLIP_SETTLE   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_done,
  input  logic                          realign,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_bitslip_ctrl,
  output logic [$clog2(DATA_WIDTH)-1:0] slip_count,
  output logic                          aligned,
  output logic                          align_error,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid
);

  localparam int SW   = $clog2(DATA_WIDTH);
  localparam int SETW = $clog2(SLIP_SETTLE + 1);
  localparam int MCW  = $clog2(MATCH_COUNT + 1);

  // Counter reload / terminal values sized to their registers.
  localparam logic [SETW-1:0] SETTLE_LOAD = SETW'(SLIP_SETTLE - 1);
  localparam logic [MCW-1:0]  MATCH_LAST  = MCW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0]   SLIP_LAST   = SW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    SLIP   = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_t;

  state_t          state;
  logic [SETW-1:0] settle_cnt;
  logic [MCW-1:0]  match_cnt;

  // Alignment FSM; every output is set on the edge that enters its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      match_cnt       <= '0;
      rx_bitslip_ctrl <= 1'b0;
      slip_count      <= '0;
      aligned         <= 1'b0;
      align_error     <= 1'b0;
      data_out        <= '0;
      data_valid      <= 1'b0;
    end else begin
      // The bitslip pulse is only ever one cycle wide.
      rx_bitslip_ctrl <= 1'b0;

      if (state != IDLE && (!init_done || realign)) begin
        // Losing init_done or a realign request abandons everything.
        state       <= IDLE;
        settle_cnt  <= '0;
        match_cnt   <= '0;
        slip_count  <= '0;
        aligned     <= 1'b0;
        align_error <= 1'b0;
        data_out    <= '0;
        data_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (init_done) begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
              slip_count <= '0;
            end
          end

          SETTLE: begin
            if (settle_cnt == '0) begin
              state     <= CHECK;
              match_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end

          CHECK: begin
            if (rx_data == TRAIN_PATTERN) begin
              if (match_cnt == MATCH_LAST) begin
                state      <= LOCKED;
                aligned    <= 1'b1;
                data_valid <= 1'b1;
                data_out   <= rx_data;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else if (slip_count == SLIP_LAST) begin
              // Every boundary position has been tried.
              state       <= FAIL;
              align_error <= 1'b1;
              aligned     <= 1'b0;
            end else begin
              state           <= SLIP;
              rx_bitslip_ctrl <= 1'b1;
              slip_count      <= slip_count + 1'b1;
            end
          end

          SLIP: begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end

          LOCKED: begin
            // Payload is arbitrary, so no pattern checking here.
            data_out <= rx_data;
          end

          FAIL: begin
            // Parked until init_done drops or realign is requested.
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
// Directed testbench for lvds_rx_word_aligner with a small receiver model
// (rotating training word that responds to bitslip) and a payload scoreboard.
module tb_lvds_rx_word_aligner;

  localparam logic [9:0] TRAIN = 10'b1111100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic       realign;
  logic [9:0] rx_data;
  logic       rx_bitslip_ctrl;
  logic [3:0] slip_count;
  logic       aligned;
  logic       align_error;
  logic [9:0] data_out;
  logic       data_valid;

  lvds_rx_word_aligner dut (
    .clk             (clk),
    .rst             (rst),
    .init_done       (init_done),
    .realign         (realign),
    .rx_data         (rx_data),
    .rx_bitslip_ctrl (rx_bitslip_ctrl),
    .slip_count      (slip_count),
    .aligned         (aligned),
    .align_error     (align_error),
    .data_out        (data_out),
    .data_valid      (data_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Receiver model state.
  int  mode;        // 0 rotated pattern, 1 constant 10'h155, 2 random payload
  int  offset;      // current rotation of the training word
  bit  follow;      // model rotates on each bitslip pulse
  int  corrupt_at;  // tick on which a single bad word is driven
  bit  sb_on;       // compare data_out against scoreboard
  int  tick_n;
  int  pulses;
  int  last_pulse;
  logic [9:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rot(input logic [9:0] w, input int n);
    logic [19:0] d;
    d = {w, w} >> (10 - n);
    return d[9:0];
  endfunction

  // One clock cycle: observe outputs at the falling edge, then drive rx_data.
  task automatic tick();
    logic [9:0] exp_word;
    @(negedge clk);
    tick_n++;
    if (sb_on && sb_q.size() > 0) begin
      exp_word = sb_q.pop_front();
      check("data_out", {22'd0, data_out}, {22'd0, exp_word});
      check("data_valid", {31'd0, data_valid}, 32'd1);
    end
    if (rx_bitslip_ctrl) begin
      pulses++;
      if (last_pulse >= 0)
        check("slip_gap", {31'd0, (tick_n - last_pulse) >= 6}, 32'd1);
      last_pulse = tick_n;
      if (follow) offset = (offset + 9) % 10;
    end
    case (mode)
      0: rx_data = rot(TRAIN, offset);
      1: rx_data = 10'h155;
      default: begin
        rx_data = 10'($urandom);
        sb_q.push_back(rx_data);
      end
    endcase
    if (tick_n == corrupt_at) rx_data = ~TRAIN;
  endtask

  task automatic begin_scn();
    tick_n     = 0;
    pulses     = 0;
    last_pulse = -1;
    init_done  = 1'b1;
    rx_data    = (mode == 1) ? 10'h155 : rot(TRAIN, offset);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init_done = 1'b0; realign = 1'b0; rx_data = '0;
    mode = 0; offset = 0; follow = 1'b1; corrupt_at = -1; sb_on = 1'b0;
    tick_n = 0; pulses = 0; last_pulse = -1;

    // Reset state
    repeat (3) tick();
    check("rst_aligned", {31'd0, aligned}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_error", {31'd0, align_error}, 32'd0);
    check("rst_bitslip", {31'd0, rx_bitslip_ctrl}, 32'd0);
    check("rst_slip_count", {28'd0, slip_count}, 32'd0);
    check("rst_data_out", {22'd0, data_out}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_aligned", {31'd0, aligned}, 32'd0);

    // Offset 0: lock exactly 21 cycles after init_done
    $display("step: offset 0");
    begin_scn();
    repeat (20) tick();
    check("off0_not_yet", {31'd0, aligned}, 32'd0);
    tick();
    check("off0_aligned", {31'd0, aligned}, 32'd1);
    check("off0_valid", {31'd0, data_valid}, 32'd1);
    check("off0_slip_count", {28'd0, slip_count}, 32'd0);
    check("off0_pulses", pulses, 32'd0);

    // Payload forwarding with one-cycle lag
    $display("step: payload scoreboard");
    mode = 2; sb_on = 1'b1;
    repeat (10) tick();
    sb_on = 1'b0; mode = 0; sb_q.delete();

    // Realign while locked
    $display("step: realign");
    realign = 1'b1;
    tick_n = 0; pulses = 0; last_pulse = -1;
    tick();
    realign = 1'b0;
    check("realign_aligned", {31'd0, aligned}, 32'd0);
    check("realign_valid", {31'd0, data_valid}, 32'd0);
    check("realign_slip_count", {28'd0, slip_count}, 32'd0);
    repeat (20) tick();
    check("relock_not_yet", {31'd0, aligned}, 32'd0);
    tick();
    check("relock_aligned", {31'd0, aligned}, 32'd1);

    // Deassert init_done while locked
    $display("step: init_done drop");
    init_done = 1'b0;
    tick();
    check("drop_aligned", {31'd0, aligned}, 32'd0);
    check("drop_valid", {31'd0, data_valid}, 32'd0);
    check("drop_data_out", {22'd0, data_out}, 32'd0);
    repeat (2) tick();

    // Offset 3: three slips, lock after 21 + 3*6 cycles
    $display("step: offset 3");
    offset = 3; follow = 1'b1;
    begin_scn();
    repeat (38) tick();
    check("off3_not_yet", {31'd0, aligned}, 32'd0);
    tick();
    check("off3_aligned", {31'd0, aligned}, 32'd1);
    check("off3_slip_count", {28'd0, slip_count}, 32'd3);
    check("off3_pulses", pulses, 32'd3);
    init_done = 1'b0;
    repeat (2) tick();

    // No match anywhere: nine slips then error
    $display("step: no match");
    mode = 1; offset = 0;
    begin_scn();
    repeat (70) tick();
    check("nm_error", {31'd0, align_error}, 32'd1);
    check("nm_aligned", {31'd0, aligned}, 32'd0);
    check("nm_slip_count", {28'd0, slip_count}, 32'd9);
    check("nm_pulses", pulses, 32'd9);
    repeat (100) tick();
    check("nm_pulses_after", pulses, 32'd9);
    check("nm_error_held", {31'd0, align_error}, 32'd1);
    init_done = 1'b0;
    tick();
    check("nm_error_cleared", {31'd0, align_error}, 32'd0);
    tick();

    // Late mismatch after 15 matches: one slip, fresh 16 matches
    $display("step: late mismatch");
    mode = 0; offset = 0; follow = 1'b0; corrupt_at = 20;
    begin_scn();
    repeat (41) tick();
    check("late_not_yet", {31'd0, aligned}, 32'd0);
    check("late_pulses", pulses, 32'd1);
    tick();
    check("late_aligned", {31'd0, aligned}, 32'd1);
    check("late_slip_count", {28'd0, slip_count}, 32'd1);
    corrupt_at = -1; follow = 1'b1;
    init_done = 1'b0;
    repeat (2) tick();

    // Asynchronous reset during a SLIP cycle
    $display("step: reset mid-slip");
    offset = 3;
    begin_scn();
    for (int i = 0; i < 20 && !rx_bitslip_ctrl; i++) tick();
    check("slip_seen", {31'd0, rx_bitslip_ctrl}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_bitslip", {31'd0, rx_bitslip_ctrl}, 32'd0);
    check("arst_slip_count", {28'd0, slip_count}, 32'd0);
    check("arst_aligned", {31'd0, aligned}, 32'd0);
    init_done = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_aligned", {31'd0, aligned}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
